// File: rtl/video_line_packer.sv
// Packs 12-bit video samples into framed 16-bit line packets (header, line number,
// data words, checksum tail) behind a first-word-fall-through output FIFO.
module video_line_packer #(
  parameter int unsigned LINE_LEN      = 1024,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [15:0] HDR_WORD      = 16'hA5A5,
  parameter logic [15:0] LINE_NUM_INIT = 16'h0000
) (
  input  logic        sclk_full,
  input  logic        n_rst,
  input  logic        enable,
  input  logic [11:0] parall_data,
  input  logic        sample_ena,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(LINE_LEN + 1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(LINE_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_NUM, S_DATA, S_TAIL} state_t;

  state_t        r_state;
  logic          r_in_vld;
  logic [11:0]   r_in_data;
  logic          r_pend_vld;
  logic [11:0]   r_pend_data;
  logic [CW-1:0] r_cnt;
  logic [11:0]   r_csum;
  logic [15:0]   r_line;
  logic          r_ovf;
  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_data_ok;
  logic        w_push_pend;
  logic        w_push_in;
  logic        w_push_data;
  logic        w_push_ctl;
  logic        w_push;
  logic        w_drop;
  logic [11:0] w_data_word;
  logic [15:0] w_push_word;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && m_ready;
  assign w_data_ok   = (r_state == S_DATA) && !w_full;
  // The pending sample is older than the staged one, so it always goes first.
  assign w_push_pend = w_data_ok && r_pend_vld;
  assign w_push_in   = w_data_ok && !r_pend_vld && r_in_vld;
  assign w_push_data = w_push_pend || w_push_in;
  assign w_data_word = w_push_pend ? r_pend_data : r_in_data;
  assign w_push_ctl  = ((r_state == S_HDR) || (r_state == S_NUM) || (r_state == S_TAIL)) && !w_full;
  assign w_push      = w_push_data || w_push_ctl;
  assign w_drop      = r_in_vld && r_pend_vld && !w_push_pend;

  always_comb begin
    w_push_word = HDR_WORD;
    case (r_state)
      S_NUM:   w_push_word = r_line;
      S_DATA:  w_push_word = {4'hD, w_data_word};
      S_TAIL:  w_push_word = {4'hE, r_csum};
      default: w_push_word = HDR_WORD;
    endcase
  end

  assign m_valid  = !w_empty;
  assign m_data   = w_empty ? 16'h0000 : r_mem[r_rd];
  assign overflow = r_ovf;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge sclk_full) begin
    if (w_push) r_mem[r_wr] <= w_push_word;
  end

  always_ff @(posedge sclk_full or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_in_vld    <= 1'b0;
      r_in_data   <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_data <= '0;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_line      <= LINE_NUM_INIT;
      r_ovf       <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
    end else begin
      r_in_vld  <= sample_ena && (r_state != S_IDLE);
      r_in_data <= parall_data;

      // Staged sample either pushes, parks in pending, or is dropped.
      if (w_push_pend) begin
        r_pend_vld  <= r_in_vld;
        r_pend_data <= r_in_data;
      end else if (r_in_vld && !w_push_in && !r_pend_vld) begin
        r_pend_vld  <= 1'b1;
        r_pend_data <= r_in_data;
      end

      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;

      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      case (r_state)
        S_IDLE: if (enable) r_state <= S_HDR;
        S_HDR: if (!w_full) begin
          r_csum  <= '0;
          r_state <= S_NUM;
        end
        S_NUM: if (!w_full) r_state <= S_DATA;
        S_DATA: if (w_push_data) begin
          r_csum <= r_csum + w_data_word;
          if (r_cnt == LAST_C) begin
            r_cnt   <= '0;
            r_state <= S_TAIL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TAIL: if (!w_full) begin
          r_line  <= r_line + 16'd1;
          r_state <= enable ? S_HDR : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_line_packer.sv
// Directed bench: dut_a (LINE_LEN=4, depth 16) for framing/checksum/enable/reset,
// dut_b (LINE_LEN=4, depth 4, line number preloaded to FFFE) for backpressure and wrap.
module tb_video_line_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_en, a_se, a_mv, a_mr, a_ovf, a_clr, a_busy;
  logic [11:0] a_pd;
  logic [15:0] a_md;
  logic        b_rst_n, b_en, b_se, b_mv, b_mr, b_ovf, b_clr, b_busy;
  logic [11:0] b_pd;
  logic [15:0] b_md;

  video_line_packer #(.LINE_LEN(4), .FIFO_DEPTH(16)) dut_a (
    .sclk_full(clk), .n_rst(a_rst_n), .enable(a_en), .parall_data(a_pd),
    .sample_ena(a_se), .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr),
    .overflow(a_ovf), .clr_ovf(a_clr), .busy(a_busy));

  video_line_packer #(.LINE_LEN(4), .FIFO_DEPTH(4), .LINE_NUM_INIT(16'hFFFE)) dut_b (
    .sclk_full(clk), .n_rst(b_rst_n), .enable(b_en), .parall_data(b_pd),
    .sample_ena(b_se), .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr),
    .overflow(b_ovf), .clr_ovf(b_clr), .busy(b_busy));

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  int checks = 0;
  int errors = 0;

  // Inputs only change at posedge+1, so a word valid/ready at negedge transfers next edge.
  always @(negedge clk) begin
    if (a_rst_n && a_mv && a_mr) qa.push_back(a_md);
    if (b_rst_n && b_mv && b_mr) qb.push_back(b_md);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [11:0] d);
    a_pd = d; a_se = 1'b1; tick(); a_se = 1'b0;
    repeat (27) tick();
  endtask

  task automatic send_b(input logic [11:0] d);
    b_pd = d; b_se = 1'b1; tick(); b_se = 1'b0;
    repeat (27) tick();
  endtask

  task automatic wait_q(input bit use_b, input int n, input string tag);
    int k = 0;
    while (((use_b ? qb.size() : qa.size()) < n) && (k < 2000)) begin
      tick();
      k++;
    end
    chk({"wait_", tag}, 16'(use_b ? qb.size() : qa.size()), 16'(n));
  endtask

  task automatic chk_seq(input bit use_b, input string tag, input logic [15:0] exp[]);
    logic [15:0] obs;
    for (int i = 0; i < exp.size(); i++) begin
      if (use_b) obs = (i < qb.size()) ? qb[i] : 16'hxxxx;
      else       obs = (i < qa.size()) ? qa[i] : 16'hxxxx;
      chk($sformatf("%s[%0d]", tag, i), obs, exp[i]);
    end
  endtask

  initial begin
    logic [15:0] exp_a[];
    logic [15:0] exp_b[];
    a_rst_n = 1'b0; a_en = 1'b0; a_se = 1'b0; a_pd = '0; a_mr = 1'b1; a_clr = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b0; b_se = 1'b0; b_pd = '0; b_mr = 1'b0; b_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 16'(a_mv), 16'd0);
    chk("rst_data", a_md, 16'h0000);
    chk("rst_ovf", 16'(a_ovf), 16'd0);
    chk("rst_busy", 16'(a_busy), 16'd0);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // Samples in IDLE are ignored entirely.
    send_a(12'h123);
    chk("idle_busy", 16'(a_busy), 16'd0);
    chk("idle_ovf", 16'(a_ovf), 16'd0);
    chk("idle_words", 16'(qa.size()), 16'd0);

    // Nominal line, checksum wrap line, then enable dropped mid-line.
    a_en = 1'b1;
    repeat (10) tick();
    chk("run_busy", 16'(a_busy), 16'd1);
    send_a(12'h001); send_a(12'h002); send_a(12'h003); send_a(12'h004);
    send_a(12'hFFF); send_a(12'hFFF); send_a(12'h002); send_a(12'h000);
    send_a(12'h011); send_a(12'h022);
    a_en = 1'b0;
    send_a(12'h033); send_a(12'h044);
    wait_q(1'b0, 21, "lines");
    repeat (20) tick();
    exp_a = '{16'hA5A5, 16'h0000, 16'hD001, 16'hD002, 16'hD003, 16'hD004, 16'hE00A,
              16'hA5A5, 16'h0001, 16'hDFFF, 16'hDFFF, 16'hD002, 16'hD000, 16'hE000,
              16'hA5A5, 16'h0002, 16'hD011, 16'hD022, 16'hD033, 16'hD044, 16'hE0AA};
    chk_seq(1'b0, "lineA", exp_a);
    chk("no_extra_hdr", 16'(qa.size()), 16'd21);
    chk("drop_busy", 16'(a_busy), 16'd0);
    chk("drop_valid", 16'(a_mv), 16'd0);

    // Reset after the second data word of line 3.
    qa.delete();
    a_en = 1'b1;
    repeat (10) tick();
    send_a(12'h055); send_a(12'h066);
    wait_q(1'b0, 4, "pre_rst");
    chk("pre_rst_num", qa[1], 16'h0003);
    chk("pre_rst_d1", qa[3], 16'hD066);
    a_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(a_mv), 16'd0);
    chk("mid_rst_data", a_md, 16'h0000);
    chk("mid_rst_ovf", 16'(a_ovf), 16'd0);
    chk("mid_rst_busy", 16'(a_busy), 16'd0);
    tick();
    qa.delete();
    a_rst_n = 1'b1;
    wait_q(1'b0, 2, "post_rst");
    exp_a = '{16'hA5A5, 16'h0000};
    chk_seq(1'b0, "postrst", exp_a);

    // Backpressure on the 4-deep FIFO: hdr, num, s1, s2 fill it; s3 parks; s4 drops.
    b_en = 1'b1;
    repeat (8) tick();
    chk("bp_valid", 16'(b_mv), 16'd1);
    chk("bp_head", b_md, 16'hA5A5);
    send_b(12'h100); send_b(12'h200); send_b(12'h300);
    chk("bp_no_ovf", 16'(b_ovf), 16'd0);
    send_b(12'h7FF);
    chk("bp_ovf", 16'(b_ovf), 16'd1);
    chk("bp_hold", b_md, 16'hA5A5);
    chk("bp_none_taken", 16'(qb.size()), 16'd0);
    b_clr = 1'b1; tick(); b_clr = 1'b0;
    chk("bp_clr", 16'(b_ovf), 16'd0);
    b_mr = 1'b1;
    repeat (5) tick();
    send_b(12'h400);
    wait_q(1'b1, 9, "bp");
    // Line FFFF then the wrapped line 0000, which ends the run after enable drops.
    send_b(12'h001); send_b(12'h001); send_b(12'h001); send_b(12'h001);
    b_en = 1'b0;
    send_b(12'h010); send_b(12'h010); send_b(12'h010); send_b(12'h010);
    wait_q(1'b1, 21, "wrap");
    repeat (20) tick();
    exp_b = '{16'hA5A5, 16'hFFFE, 16'hD100, 16'hD200, 16'hD300, 16'hD400, 16'hEA00,
              16'hA5A5, 16'hFFFF, 16'hD001, 16'hD001, 16'hD001, 16'hD001, 16'hE004,
              16'hA5A5, 16'h0000, 16'hD010, 16'hD010, 16'hD010, 16'hD010, 16'hE040};
    chk_seq(1'b1, "lineB", exp_b);
    chk("b_total", 16'(qb.size()), 16'd21);
    chk("b_idle_busy", 16'(b_busy), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_line_packer.md
VIDEO_LINE_PACKER -- requirements
Module: video_line_packer

Interface
REQ-001 SHALL have parameter LINE_LEN, default 1024, samples per line (range 1..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, at least 4).
REQ-003 SHALL have parameter HDR_WORD, default 16'hA5A5, line start marker.
REQ-004 SHALL have port sclk_full  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  input  1  line capture enable (level).
REQ-007 SHALL have port parall_data  input  12  sample from the video SPI reader.
REQ-008 SHALL have port sample_ena  input  1  one-cycle strobe; parall_data valid this cycle.
REQ-009 SHALL have port m_data  output  16  output stream word.
REQ-010 SHALL have port m_valid  output  1  m_data valid.
REQ-011 SHALL have port m_ready  input  1  consumer accepts; transfer when m_valid and m_ready are both high on a clock edge.
REQ-012 SHALL have port overflow  output  1  sticky sample-loss flag.
REQ-013 SHALL have port clr_ovf  input  1  clears overflow.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL emit per line, in order: HDR_WORD; line number (16 bit); LINE_LEN data words {4'hD, sample}; tail word {4'hE, checksum}.
REQ-016 SHALL compute checksum as the sum of the line's samples mod 4096, cleared at each header.
REQ-017 SHALL increment the line number after each tail word, wrapping 16'hFFFF -> 16'h0000; the line number resets to 0 only on reset.
REQ-018 SHALL implement the FSM IDLE -> HDR -> NUM -> DATA -> TAIL.
- IDLE: go to HDR when enable=1.
- HDR, NUM, TAIL: each pushes its word in the first cycle the FIFO is not full, then advances.
- DATA: go to TAIL after LINE_LEN samples have been pushed.
- TAIL: go to HDR if enable=1, else IDLE.
REQ-019 SHALL sample enable only in IDLE and TAIL; deasserting enable mid-line completes the current line, including its tail.
REQ-020 SHALL push a sample into the FIFO in the cycle after sample_ena when the state is DATA and the FIFO is not full.
REQ-021 SHALL hold a sample in a one-entry pending register if it cannot be pushed (state HDR/NUM/TAIL, or FIFO full); the pending sample is pushed first once the state is DATA and the FIFO is not full.
REQ-022 SHALL drop a sample and set overflow when the sample arrives while the pending register is occupied; a dropped sample does not count toward LINE_LEN or the checksum.
REQ-023 SHALL ignore sample_ena in IDLE (no store, no overflow).
REQ-024 SHALL never push more than one word per cycle; the FIFO is first-word-fall-through, with m_valid = not empty.
REQ-025 SHALL block a push when the FIFO holds FIFO_DEPTH words, even if a pop occurs the same cycle; a pop and a push in one cycle leave the count unchanged.
REQ-026 SHALL hold m_data stable while m_valid=1 and m_ready=0.
REQ-027 SHALL clear overflow on clr_ovf; if clr_ovf and a new drop occur in the same cycle, overflow ends set.

Reset
REQ-028 SHALL on n_rst=0, asynchronously:
- set state to IDLE;
- empty the FIFO, so m_valid=0 and m_data=0;
- set overflow=0 and busy=0;
- clear the line number, checksum, sample counter and pending register.
REQ-029 SHALL on reset mid-line discard all partial line data; after release the first output is a fresh header with line number 0.

Verification (LINE_LEN=4, FIFO_DEPTH=16, m_ready=1 unless stated)
REQ-030 SHALL cover nominal line: enable=1, samples 12'h001, 002, 003, 004 every 28 cycles -> A5A5, 0000, D001, D002, D003, D004, E00A; the next header carries line number 0001.
REQ-031 SHALL cover backpressure: m_ready=0 throughout a line with FIFO_DEPTH=4 -> FIFO fills, the first sample sits in pending, the next sample sets overflow; after m_ready=1 the stream resumes with no duplicated words.
REQ-032 SHALL cover checksum wrap: samples FFF, FFF, 002, 000 -> tail E000.
REQ-033 SHALL cover enable drop: enable->0 after the 2nd sample -> the line completes with 4 data words and a tail, then IDLE with busy=0 and no further header.
REQ-034 SHALL cover reset mid-line: n_rst pulsed after the 2nd data word -> m_valid=0 immediately, overflow=0; after release the header is A5A5, 0000.
REQ-035 SHALL cover line-number wrap: force 65536 lines (or preload via a test hook) -> the line number after FFFF is 0000.
